min_crc32_frame: RTL and testbench

Computes the MIN frame CRC32 over the ID/control byte, length byte and payload, directly upstream of the MIN transmit FSM. Latches one frame's ID and payload on a start request, processes one byte per clock, then presents the CRC together with the frozen ID and payload. The transmitter's `i_id`, `i_data`, `i_crc32` and `i_en` inputs connect directly to this block's outputs.

---
 rtl/min_pkg.sv | 23 ++
 rtl/crc32_byte.sv | 26 ++
 rtl/min_crc32_frame.sv | 123 ++++++++++++
 tb/tb_min_crc32_frame.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/min_pkg.sv
// Shared MIN protocol package.
// Holds the MIN framing bytes, the CRC-32/ISO-HDLC (zlib) constants used by
// both the transmit-side frame CRC and the receive path, and the state
// encoding of the frame CRC engine.
package min_pkg;

  // MIN framing bytes
  localparam logic [7:0] SOF   = 8'hAA;
  localparam logic [7:0] EOF   = 8'h55;
  localparam logic [7:0] STUFF = 8'h55;

  // CRC-32/ISO-HDLC: reflected polynomial, LSB-first, inverted in and out
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT    = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } crc_state_e;

endpackage

// File: rtl/crc32_byte.sv
// Combinational CRC-32 byte fold.
// Folds one byte into a running reflected CRC-32 register (no init/final XOR
// applied here). Eight unrolled shift/XOR steps, LSB of the byte first.
// Ports:
//   i_crc  [31:0]  running CRC register
//   i_byte [7:0]   byte to fold in
//   o_crc  [31:0]  CRC register after the fold
module crc32_byte
  import min_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_crc
);

  logic [31:0] crc_w;

  always_comb begin
    crc_w = i_crc ^ {24'h000000, i_byte};
    for (int b = 0; b < 8; b++) begin
      crc_w = crc_w[0] ? ((crc_w >> 1) ^ CRC32_POLY_REFL) : (crc_w >> 1);
    end
    o_crc = crc_w;
  end

endmodule

// File: rtl/min_crc32_frame.sv
// MIN frame CRC32 engine, sitting in front of the MIN transmit FSM.
// On an accepted start it latches the ID and payload, then folds one byte per
// clock in the order: ID, length byte, payload MSB byte first. When the last
// byte is folded the final CRC is registered and o_done pulses for one cycle.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_start          request a CRC over the current i_id / i_data
//   i_id, i_data     frame ID/control byte and payload (MSB byte first)
//   o_busy           high while bytes are being folded
//   o_done           one-cycle pulse, o_crc32 valid
//   o_id, o_data     frozen copy of the accepted frame
//   o_crc32          final CRC, held until the next CALC exit
module min_crc32_frame
  import min_pkg::*;
#(
  parameter int N_DATA_BYTE = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [7:0]               i_id,
  input  logic [8*N_DATA_BYTE-1:0] i_data,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [7:0]               o_id,
  output logic [8*N_DATA_BYTE-1:0] o_data,
  output logic [31:0]              o_crc32
);

  localparam int              L        = N_DATA_BYTE + 2;
  localparam int              IW       = $clog2(L);
  localparam logic [IW-1:0]   LAST_IDX = IW'(L - 1);
  localparam logic [7:0]      LEN_BYTE = 8'(N_DATA_BYTE);

  crc_state_e                 state_q, state_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [31:0]                crc_q, crc_d;
  logic [7:0]                 id_q, id_d;
  logic [8*N_DATA_BYTE-1:0]   data_q, data_d;
  logic [31:0]                crc_out_q, crc_out_d;
  logic [7:0]                 byte_cur;
  logic [31:0]                crc_next;

  // Byte selected by the index: 0 = ID, 1 = length, 2.. = payload MSB first
  always_comb begin
    byte_cur = 8'h00;
    if (idx_q == '0) begin
      byte_cur = id_q;
    end else if (idx_q == IW'(1)) begin
      byte_cur = LEN_BYTE;
    end
    for (int j = 0; j < N_DATA_BYTE; j++) begin
      if (idx_q == IW'(j + 2)) begin
        byte_cur = data_q[8*(N_DATA_BYTE-1-j) +: 8];
      end
    end
  end

  crc32_byte u_fold (
    .i_crc  (crc_q),
    .i_byte (byte_cur),
    .o_crc  (crc_next)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    crc_d     = crc_q;
    id_d      = id_q;
    data_d    = data_q;
    crc_out_d = crc_out_q;
    case (state_q)
      // DONE behaves like IDLE for start acceptance, so back-to-back frames
      // lose no cycle.
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (i_start) begin
          state_d = ST_CALC;
          id_d    = i_id;
          data_d  = i_data;
          idx_d   = '0;
          crc_d   = CRC32_INIT;
        end
      end
      ST_CALC: begin
        crc_d = crc_next;
        if (idx_q == LAST_IDX) begin
          // Index stays at the last byte rather than wrapping
          crc_out_d = crc_next ^ CRC32_XOROUT;
          state_d   = ST_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      crc_q     <= CRC32_INIT;
      id_q      <= '0;
      data_q    <= '0;
      crc_out_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      crc_q     <= crc_d;
      id_q      <= id_d;
      data_q    <= data_d;
      crc_out_q <= crc_out_d;
    end
  end

  assign o_busy  = (state_q == ST_CALC);
  assign o_done  = (state_q == ST_DONE);
  assign o_id    = id_q;
  assign o_data  = data_q;
  assign o_crc32 = crc_out_q;

endmodule

// File: tb/tb_min_crc32_frame.sv
// Testbench for min_crc32_frame: directed checks on an N=4 instance,
// randomised frames on N=1 and N=8 instances, and a unit check of crc32_byte.
// Expected frames go into per-instance queues; a monitor compares on o_done.
module tb_min_crc32_frame;

  typedef struct {
    logic [7:0]  id;
    logic [63:0] data;
    logic [31:0] crc;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // N=4 instance
  logic s4 = 1'b0; logic [7:0] id4 = 8'h00; logic [31:0] d4 = '0;
  logic busy4, done4; logic [7:0] oid4; logic [31:0] od4; logic [31:0] crc4;
  // N=1 instance
  logic s1 = 1'b0; logic [7:0] id1 = 8'h00; logic [7:0] d1 = '0;
  logic busy1, done1; logic [7:0] oid1; logic [7:0] od1; logic [31:0] crc1;
  // N=8 instance
  logic s8 = 1'b0; logic [7:0] id8 = 8'h00; logic [63:0] d8 = '0;
  logic busy8, done8; logic [7:0] oid8; logic [63:0] od8; logic [31:0] crc8;
  // crc32_byte unit
  logic [31:0] cb_in = '0; logic [7:0] cb_byte = '0; logic [31:0] cb_out;

  min_crc32_frame #(.N_DATA_BYTE(4)) u4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s4), .i_id(id4), .i_data(d4),
    .o_busy(busy4), .o_done(done4), .o_id(oid4), .o_data(od4), .o_crc32(crc4));
  min_crc32_frame #(.N_DATA_BYTE(1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s1), .i_id(id1), .i_data(d1),
    .o_busy(busy1), .o_done(done1), .o_id(oid1), .o_data(od1), .o_crc32(crc1));
  min_crc32_frame #(.N_DATA_BYTE(8)) u8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s8), .i_id(id8), .i_data(d8),
    .o_busy(busy8), .o_done(done8), .o_id(oid8), .o_data(od8), .o_crc32(crc8));
  crc32_byte u_cb (.i_crc(cb_in), .i_byte(cb_byte), .o_crc(cb_out));

  exp_t q4[$]; exp_t q1[$]; exp_t q8[$];
  int nd4 = 0; int nd1 = 0; int nd8 = 0;

  // Table-driven zlib CRC reference
  logic [31:0] tbl [256];

  task automatic build_tbl();
    for (int i = 0; i < 256; i++) begin
      logic [31:0] c;
      c = 32'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      tbl[i] = c;
    end
  endtask

  function automatic logic [31:0] ref_crc(input logic [7:0] id, input logic [63:0] d, input int n);
    logic [7:0]  bl[$];
    logic [31:0] c;
    bl.push_back(id);
    bl.push_back(8'(n));
    for (int j = n - 1; j >= 0; j--) bl.push_back(d[8*j +: 8]);
    c = 32'hFFFFFFFF;
    foreach (bl[i]) c = tbl[8'(c ^ {24'h0, bl[i]})] ^ (c >> 8);
    return ~c;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic set_in(input int which, input logic s, input logic [7:0] id, input logic [63:0] d);
    case (which)
      4: begin s4 = s; id4 = id; d4 = d[31:0]; end
      1: begin s1 = s; id1 = id; d1 = d[7:0]; end
      default: begin s8 = s; id8 = id; d8 = d; end
    endcase
  endtask

  function automatic logic get_done(input int which);
    case (which)
      4: return done4;
      1: return done1;
      default: return done8;
    endcase
  endfunction

  // Issue a start at the current negedge and record what the frame must produce
  task automatic issue(input int which, input logic [7:0] id, input logic [63:0] d);
    exp_t e;
    int   n;
    n = which;
    e.id = id; e.data = d; e.crc = ref_crc(id, d, n); e.cyc = cyc + n + 3;
    set_in(which, 1'b1, id, d);
    case (which)
      4: q4.push_back(e);
      1: q1.push_back(e);
      default: q8.push_back(e);
    endcase
  endtask

  task automatic mon_check(input int which, input logic [7:0] aid, input logic [63:0] ad, input logic [31:0] acrc);
    exp_t e;
    int   sz;
    case (which)
      4: sz = q4.size();
      1: sz = q1.size();
      default: sz = q8.size();
    endcase
    checks++;
    if (sz == 0) begin
      failures++;
      $display("FAIL unexpected_done inst=N%0d actual=done expected=no_done", which);
    end else begin
      case (which)
        4: e = q4.pop_front();
        1: e = q1.pop_front();
        default: e = q8.pop_front();
      endcase
      chk($sformatf("N%0d_crc", which), {32'h0, acrc}, {32'h0, e.crc});
      chk($sformatf("N%0d_id", which), {56'h0, aid}, {56'h0, e.id});
      chk($sformatf("N%0d_data", which), ad, e.data);
      chk($sformatf("N%0d_done_cycle", which), 64'(cyc), 64'(e.cyc));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done4 === 1'b1) begin nd4++; mon_check(4, oid4, {32'h0, od4}, crc4); end
      if (done1 === 1'b1) begin nd1++; mon_check(1, oid1, {56'h0, od1}, crc1); end
      if (done8 === 1'b1) begin nd8++; mon_check(8, oid8, od8, crc8); end
    end
  end

  task automatic rand_frames(input int which, input int nfr);
    logic [7:0]  id;
    logic [63:0] d;
    int          budget;
    int          gap;
    @(negedge clk);
    for (int f = 0; f < nfr; f++) begin
      id = 8'($urandom);
      d  = {$urandom, $urandom};
      if (which == 1) d = {56'h0, d[7:0]};
      issue(which, id, d);
      @(negedge clk);
      set_in(which, 1'b0, 8'($urandom), {$urandom, $urandom});
      budget = 0;
      // Spurious starts while busy must be ignored
      while (get_done(which) !== 1'b1 && budget < which + 6) begin
        set_in(which, ($urandom % 3) == 0, 8'($urandom), {$urandom, $urandom});
        @(negedge clk);
        budget++;
      end
      if (get_done(which) !== 1'b1) begin
        chk($sformatf("N%0d_done_timeout", which), 64'd0, 64'd1);
        break;
      end
      set_in(which, 1'b0, 8'h00, 64'h0);
      gap = $urandom % 4;
      repeat (gap) @(negedge clk);
    end
    set_in(which, 1'b0, 8'h00, 64'h0);
    repeat (which + 4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string       s;
    logic [31:0] c;
    int          bc, n0, k;
    build_tbl();

    // crc32_byte unit check
    s = "123456789";
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) begin
      cb_in = c; cb_byte = s[i]; #1; c = cb_out;
    end
    chk("crc32_byte_123456789", {32'h0, c ^ 32'hFFFFFFFF}, 64'hCBF43926);
    cb_in = 32'hFFFFFFFF; cb_byte = 8'h00; #1;
    chk("crc32_byte_zero", {32'h0, cb_out ^ 32'hFFFFFFFF}, 64'hD202EF8D);

    // Reset state
    rst_n = 1'b0; #1;
    chk("rst_busy", {63'h0, busy4}, 64'h0);
    chk("rst_done", {63'h0, done4}, 64'h0);
    chk("rst_id", {56'h0, oid4}, 64'h0);
    chk("rst_data", {32'h0, od4}, 64'h0);
    chk("rst_crc", {32'h0, crc4}, 64'h0);
    chk("rst_crc_n8", {32'h0, crc8}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame with busy-length count
    n0 = nd4; bc = 0;
    issue(4, 8'h01, 64'hDEADBEEF);
    repeat (10) begin
      @(negedge clk);
      set_in(4, 1'b0, 8'h01, 64'hDEADBEEF);
      if (busy4 === 1'b1) bc++;
    end
    chk("basic_busy_cycles", 64'(bc), 64'd6);
    chk("basic_done_count", 64'(nd4 - n0), 64'd1);

    // Start while busy is ignored
    n0 = nd4;
    issue(4, 8'h01, 64'h12345678);
    @(negedge clk); set_in(4, 1'b0, 8'h01, 64'h12345678);
    repeat (2) @(negedge clk);
    set_in(4, 1'b1, 8'h02, 64'hCAFEF00D);
    @(negedge clk); set_in(4, 1'b0, 8'h02, 64'hCAFEF00D);
    repeat (10) @(negedge clk);
    chk("busy_start_id", {56'h0, oid4}, 64'h01);
    chk("busy_start_done_count", 64'(nd4 - n0), 64'd1);

    // Back-to-back with start held high
    n0 = nd4;
    issue(4, 8'h10, 64'hA5A55A5A);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (done4 !== 1'b1 && k < 20);
    if (done4 === 1'b1) issue(4, 8'h11, 64'h0F1E2D3C);
    else chk("b2b_first_done_timeout", 64'd0, 64'd1);
    @(negedge clk); set_in(4, 1'b0, 8'h11, 64'h0F1E2D3C);
    repeat (10) @(negedge clk);
    chk("b2b_done_count", 64'(nd4 - n0), 64'd2);

    // Asynchronous reset during the third CALC cycle
    n0 = nd4;
    issue(4, 8'h33, 64'h01020304);
    repeat (3) @(posedge clk);
    set_in(4, 1'b0, 8'h33, 64'h01020304);
    #2 rst_n = 1'b0;
    #1;
    q4.delete();
    chk("midrst_busy", {63'h0, busy4}, 64'h0);
    chk("midrst_done", {63'h0, done4}, 64'h0);
    chk("midrst_id", {56'h0, oid4}, 64'h0);
    chk("midrst_data", {32'h0, od4}, 64'h0);
    chk("midrst_crc", {32'h0, crc4}, 64'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_no_done", 64'(nd4 - n0), 64'd0);
    issue(4, 8'h5A, 64'h89ABCDEF);
    @(negedge clk); set_in(4, 1'b0, 8'h00, 64'h0);
    repeat (10) @(negedge clk);
    chk("midrst_fresh_done_count", 64'(nd4 - n0), 64'd1);

    // Randomised frames on N=1 and N=8 in parallel
    n0 = nd1; k = nd8;
    fork
      rand_frames(1, 1000);
      rand_frames(8, 1000);
    join
    chk("rand_n1_done_count", 64'(nd1 - n0), 64'd1000);
    chk("rand_n8_done_count", 64'(nd8 - k), 64'd1000);
    chk("rand_n1_queue_empty", 64'(q1.size()), 64'd0);
    chk("rand_n8_queue_empty", 64'(q8.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
